// File: rtl/led_frame_encoder.sv
// Serialises one data word onto the LED line as preamble, data (MSB first),
// optional even parity and stop, in NRZ or Manchester form.
module led_frame_encoder #(
   parameter int unsigned FRAME_SIZE    = 16,
   parameter int unsigned CLKS_PER_BIT  = 4,
   parameter int unsigned PREAMBLE_BITS = 4,
   parameter int unsigned PARITY_EN     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [FRAME_SIZE-1:0] data,
   input  logic                  start,
   input  logic                  manchester,
   output logic                  led,
   output logic                  busy,
   output logic                  irq
);

   localparam int unsigned TOTAL = PREAMBLE_BITS + FRAME_SIZE + PARITY_EN + 1;
   localparam int unsigned BIT_W = $clog2(TOTAL + 1);
   localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL - 1);
   localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT % 2 != 0) begin : g_odd_bit_period
      $error("led_frame_encoder: Manchester needs an even CLKS_PER_BIT >= 2");
   end

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                state, state_n;
   logic [CYC_W-1:0]      cyc_cnt, cyc_n;
   logic [BIT_W-1:0]      bit_cnt, bit_n;
   logic [FRAME_SIZE-1:0] word_q, word_n;
   logic                  man_q, man_n;
   logic                  led_n, busy_n, irq_n;

   // Line level for bit slot idx at cycle cyc within that bit period.
   function automatic logic line_level(input logic [BIT_W-1:0]      idx,
                                       input logic [CYC_W-1:0]      cyc,
                                       input logic [FRAME_SIZE-1:0] word,
                                       input logic                  man);
      logic                  value;
      logic [FRAME_SIZE-1:0] shifted;
      value   = 1'b0;
      shifted = word << (idx - BIT_W'(PREAMBLE_BITS));
      if (idx < BIT_W'(PREAMBLE_BITS))
         value = ~idx[0];
      else if (idx < BIT_W'(PREAMBLE_BITS + FRAME_SIZE))
         value = shifted[FRAME_SIZE-1];
      else
         value = ^word;
      if (man && (cyc < CYC_W'(HALF)))
         value = ~value;
      if (idx == LAST_BIT)
         value = 1'b0;
      return value;
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         bit_cnt <= '0;
         word_q  <= '0;
         man_q   <= 1'b0;
         led     <= 1'b0;
         busy    <= 1'b0;
         irq     <= 1'b0;
      end else begin
         state   <= state_n;
         cyc_cnt <= cyc_n;
         bit_cnt <= bit_n;
         word_q  <= word_n;
         man_q   <= man_n;
         led     <= led_n;
         busy    <= busy_n;
         irq     <= irq_n;
      end
   end

   // led is registered one slot ahead: each edge loads the level of the slot that edge begins.
   always_comb begin
      state_n = state;
      cyc_n   = cyc_cnt;
      bit_n   = bit_cnt;
      word_n  = word_q;
      man_n   = man_q;
      led_n   = led;
      busy_n  = busy;
      irq_n   = irq;
      case (state)
         IDLE: begin
            led_n  = 1'b0;
            busy_n = 1'b0;
            irq_n  = 1'b0;
            cyc_n  = '0;
            bit_n  = '0;
            if (start) begin
               word_n  = data;
               man_n   = manchester;
               busy_n  = 1'b1;
               state_n = SEND;
               led_n   = line_level('0, '0, data, manchester);
            end
         end
         SEND: begin
            if (cyc_cnt == LAST_CYC) begin
               cyc_n = '0;
               if (bit_cnt == LAST_BIT) begin
                  bit_n   = '0;
                  state_n = DONE;
                  led_n   = 1'b0;
                  busy_n  = 1'b0;
                  irq_n   = 1'b1;
               end else begin
                  bit_n = bit_cnt + BIT_W'(1);
                  led_n = line_level(bit_cnt + BIT_W'(1), '0, word_q, man_q);
               end
            end else begin
               cyc_n = cyc_cnt + CYC_W'(1);
               led_n = line_level(bit_cnt, cyc_cnt + CYC_W'(1), word_q, man_q);
            end
         end
         DONE: begin
            led_n  = 1'b0;
            busy_n = 1'b0;
            if (!start) begin
               irq_n   = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
